// File: rtl/pipelined_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of one carry slice; the top module rejects widths that do not divide evenly.
  function automatic int unsigned slice_width(input int unsigned data_width,
                                              input int unsigned stages);
    return (stages == 0) ? 0 : data_width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// One registered W-bit carry slice of the pipelined adder.
module pipelined_adder_slice #(
  parameter int unsigned W      = 8,
  parameter bit          HAS_OV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ov
);

  logic [W:0] sum_c;

  assign sum_c = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

  // Sum and carry register; holds while the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else if (en) begin
      s    <= sum_c[W-1:0];
      cout <= sum_c[W];
    end
  end

  if (HAS_OV) begin : g_ov
    logic c_msb;

    // Carry into the MSB recovered from the sum bit and both operand bits.
    assign c_msb = sum_c[W-1] ^ a[W-1] ^ b[W-1];

    // Signed overflow register: carry into MSB differs from carry out of MSB.
    always_ff @(posedge clk) begin
      if (rst) begin
        ov <= 1'b0;
      end else if (en) begin
        ov <= c_msb ^ sum_c[W];
      end
    end
  end else begin : g_no_ov
    // Only the most significant slice sees the sign bit.
    assign ov = 1'b0;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple adder: one carry slice per clock, valid/ready flow control with full freeze on stall.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  CI,
  input  logic                  SUB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] O,
  output logic                  CO,
  output logic                  OV
);

  localparam int unsigned W = slice_width(DATA_WIDTH, STAGES);

  if (STAGES == 0 || STAGES > DATA_WIDTH || (DATA_WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: DATA_WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
           DATA_WIDTH, STAGES);
  end

  logic                  stall;
  logic [DATA_WIDTH-1:0] b_x;
  logic [DATA_WIDTH-1:0] a_sk;
  logic [DATA_WIDTH-1:0] b_sk;
  logic [DATA_WIDTH-1:0] sum;
  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     cin;
  logic [STAGES-1:0]     cout;
  logic [STAGES-1:0]     ov_v;

  // A result waiting on a busy consumer freezes every stage.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld[STAGES-1];
  assign CO        = cout[STAGES-1];
  assign OV        = |ov_v;

  // Operand B inversion for subtract mode.
  always_comb begin
    b_x = B;
    case (SUB)
      MODE_ADD: b_x = B;
      MODE_SUB: b_x = ~B;
      default:  b_x = B;
    endcase
  end

  // Valid chain; bubbles advance as invalid entries unless frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (!stall) begin
      vld[0] <= in_valid;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned LO      = k * W;
    localparam int unsigned OUT_DLY = STAGES - 1 - k;

    if (k == 0) begin : g_in_direct
      assign a_sk[LO +: W] = A[LO +: W];
      assign b_sk[LO +: W] = b_x[LO +: W];
      assign cin[k]        = CI;
    end else begin : g_in_skew
      logic [W-1:0] a_sr [k];
      logic [W-1:0] b_sr [k];

      // Delay operand slice k by k cycles so it meets its incoming carry.
      always_ff @(posedge clk) begin
        if (!stall) begin
          a_sr[0] <= A[LO +: W];
          b_sr[0] <= b_x[LO +: W];
          for (int i = 1; i < k; i++) begin
            a_sr[i] <= a_sr[i-1];
            b_sr[i] <= b_sr[i-1];
          end
        end
      end

      assign a_sk[LO +: W] = a_sr[k-1];
      assign b_sk[LO +: W] = b_sr[k-1];
      assign cin[k]        = cout[k-1];
    end

    pipelined_adder_slice #(
      .W      (W),
      .HAS_OV (k == int'(STAGES) - 1)
    ) u_slice (
      .clk  (clk),
      .rst  (rst),
      .en   (~stall),
      .a    (a_sk[LO +: W]),
      .b    (b_sk[LO +: W]),
      .cin  (cin[k]),
      .s    (sum[LO +: W]),
      .cout (cout[k]),
      .ov   (ov_v[k])
    );

    if (OUT_DLY == 0) begin : g_out_direct
      assign O[LO +: W] = sum[LO +: W];
    end else begin : g_out_skew
      logic [W-1:0] o_sr [OUT_DLY];

      // Hold finished low slices until the top slice of the same operation completes.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < int'(OUT_DLY); i++) begin
            o_sr[i] <= '0;
          end
        end else if (!stall) begin
          o_sr[0] <= sum[LO +: W];
          for (int i = 1; i < int'(OUT_DLY); i++) begin
            o_sr[i] <= o_sr[i-1];
          end
        end
      end

      assign O[LO +: W] = o_sr[OUT_DLY-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: four adder configurations behind one shared stimulus port, selected in turn.
module tb_pipelined_adder;

  localparam int unsigned CFG_DW [4] = '{32, 32, 8, 64};
  localparam int unsigned CFG_ST [4] = '{1, 4, 8, 2};

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        sub;
    logic [63:0] o;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        ci;
  logic        sub;
  logic [63:0] a_drv;
  logic [63:0] b_drv;
  logic [1:0]  sel;

  logic [63:0] o_all [4];
  logic [3:0]  co_all;
  logic [3:0]  ov_all;
  logic [3:0]  ovld_all;
  logic [3:0]  irdy_all;

  logic [63:0] dut_o;
  logic        dut_co;
  logic        dut_ov;
  logic        dut_ovld;
  logic        dut_irdy;

  int          errors;
  int          checks;
  int          cfg;
  int          dw;
  int          stg;
  logic [63:0] msk;
  vec_t        tbl [9];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned DW = CFG_DW[g];
    localparam int unsigned ST = CFG_ST[g];
    logic [DW-1:0] o;
    logic          co;
    logic          ov;
    logic          ovld;
    logic          irdy;

    pipelined_adder #(.DATA_WIDTH(DW), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid && (sel == 2'(g))),
      .in_ready  (irdy),
      .A         (a_drv[DW-1:0]),
      .B         (b_drv[DW-1:0]),
      .CI        (ci),
      .SUB       (sub),
      .out_valid (ovld),
      .out_ready (out_ready || (sel != 2'(g))),
      .O         (o),
      .CO        (co),
      .OV        (ov)
    );

    assign o_all[g]    = 64'(o);
    assign co_all[g]   = co;
    assign ov_all[g]   = ov;
    assign ovld_all[g] = ovld;
    assign irdy_all[g] = irdy;
  end

  assign dut_o    = o_all[sel];
  assign dut_co   = co_all[sel];
  assign dut_ov   = ov_all[sel];
  assign dut_ovld = ovld_all[sel];
  assign dut_irdy = irdy_all[sel];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d (DW=%0d,ST=%0d): got %0h expected %0h",
               name, cfg, dw, stg, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic, overflow from operand/result sign rule.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic c, input logic s);
    logic [64:0] full;
    logic [63:0] bx;
    logic [63:0] o;
    logic        co;
    logic        ov;
    bx   = (s ? ~b : b) & msk;
    full = {1'b0, a & msk} + {1'b0, bx} + 65'(c);
    o    = full[63:0] & msk;
    co   = full[dw];
    ov   = (a[dw-1] == bx[dw-1]) && (o[dw-1] != a[dw-1]);
    return {co, ov, o};
  endfunction

  task automatic draw();
    a_drv = {$urandom, $urandom} & msk;
    b_drv = {$urandom, $urandom} & msk;
    ci    = 1'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic fill_table();
    logic [63:0] maxpos;
    logic [63:0] minneg;
    maxpos = msk >> 1;
    minneg = maxpos + 64'd1;
    tbl[0] = '{a: 64'd34, b: 64'd19, ci: 1'b1, sub: 1'b0, o: 64'd54,     co: 1'b0, ov: 1'b0};
    tbl[1] = '{a: msk,    b: 64'd1,  ci: 1'b0, sub: 1'b0, o: 64'd0,      co: 1'b1, ov: 1'b0};
    tbl[2] = '{a: maxpos, b: 64'd1,  ci: 1'b0, sub: 1'b0, o: minneg,     co: 1'b0, ov: 1'b1};
    tbl[3] = '{a: 64'd10, b: 64'd3,  ci: 1'b1, sub: 1'b1, o: 64'd7,      co: 1'b1, ov: 1'b0};
    tbl[4] = '{a: 64'd3,  b: 64'd10, ci: 1'b1, sub: 1'b1, o: msk - 64'd6, co: 1'b0, ov: 1'b0};
    tbl[5] = '{a: minneg, b: 64'd1,  ci: 1'b1, sub: 1'b1, o: maxpos,     co: 1'b1, ov: 1'b1};
    tbl[6] = '{a: 64'd0,  b: 64'd0,  ci: 1'b0, sub: 1'b0, o: 64'd0,      co: 1'b0, ov: 1'b0};
    tbl[7] = '{a: 64'd5,  b: 64'd5,  ci: 1'b1, sub: 1'b1, o: 64'd0,      co: 1'b1, ov: 1'b0};
    tbl[8] = '{a: msk,    b: 64'd0,  ci: 1'b1, sub: 1'b0, o: 64'd0,      co: 1'b1, ov: 1'b0};
  endtask

  // One isolated beat: exact latency, single-cycle out_valid pulse, result value.
  task automatic single_beat(input vec_t v, input string name);
    int          first;
    int          npulse;
    logic [65:0] got;
    first  = -1;
    npulse = 0;
    got    = '0;
    a_drv = v.a; b_drv = v.b; ci = v.ci; sub = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n <= stg; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (dut_ovld === 1'b1) begin
        npulse++;
        if (first < 0) begin
          first = n;
          got   = {dut_co, dut_ov, dut_o};
        end
      end
    end
    check({name, "_latency"}, 66'(first), 66'(stg - 1));
    check({name, "_pulses"}, 66'(npulse), 66'd1);
    check({name, "_value"}, got, {v.co, v.ov, v.o});
  endtask

  // Random back-to-back stream, optionally with a 5-cycle consumer stall mid-burst.
  task automatic stream(input int n, input bit stall_en, input string name);
    logic [65:0] expq [$];
    logic [65:0] held;
    logic [65:0] exp;
    bit          held_v;
    bit          fire;
    int          sent;
    int          recv;
    int          cyc;
    int          spurious;
    held_v = 1'b0; sent = 0; recv = 0; cyc = 0; spurious = 0; held = '0;
    out_ready = 1'b1;
    draw();
    in_valid = 1'b1;
    #1;
    fire = in_valid && dut_irdy;
    while (recv < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        expq.push_back(model(a_drv, b_drv, ci, sub));
        sent++;
        if (sent < n) draw();
        else in_valid = 1'b0;
      end
      out_ready = !(stall_en && cyc >= stg + 3 && cyc < stg + 8);
      #1;
      check({name, "_in_ready"}, 66'(dut_irdy), 66'(!(dut_ovld && !out_ready)));
      if (dut_ovld === 1'b1) begin
        if (out_ready) begin
          held_v = 1'b0;
          if (expq.size() == 0) begin
            check({name, "_unexpected"}, {dut_co, dut_ov, dut_o}, 66'h0);
          end else begin
            exp = expq.pop_front();
            check({name, "_result"}, {dut_co, dut_ov, dut_o}, exp);
          end
          recv++;
        end else if (held_v) begin
          check({name, "_stall_hold"}, {dut_co, dut_ov, dut_o}, held);
        end else begin
          held   = {dut_co, dut_ov, dut_o};
          held_v = 1'b1;
        end
      end
      fire = in_valid && dut_irdy;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (stg + 2) begin
      @(posedge clk); #1;
      if (dut_ovld === 1'b1) spurious++;
    end
    check({name, "_count"}, 66'(recv), 66'(n));
    check({name, "_no_extra"}, 66'(spurious), 66'd0);
  endtask

  // Fill the pipeline, pulse reset, and confirm nothing ever emerges.
  task automatic reset_midflight();
    int stale;
    stale     = 0;
    out_ready = 1'b1;
    for (int i = 0; i < stg; i++) begin
      draw();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_flush_valid", 66'(dut_ovld), 66'd0);
    check("rst_flush_data", {dut_co, dut_ov, dut_o}, 66'h0);
    repeat (2 * stg + 2) begin
      @(posedge clk); #1;
      if (dut_ovld !== 1'b0) stale++;
    end
    check("rst_no_stale", 66'(stale), 66'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_drv = '0; b_drv = '0; ci = 1'b0; sub = 1'b0; sel = 2'd0;
    for (int c = 0; c < 4; c++) begin
      cfg = c;
      sel = 2'(c);
      dw  = int'(CFG_DW[c]);
      stg = int'(CFG_ST[c]);
      msk = (dw == 64) ? '1 : ((64'd1 << dw) - 64'd1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", 66'(dut_ovld), 66'd0);
      check("reset_outputs", {dut_co, dut_ov, dut_o}, 66'h0);
      check("reset_in_ready", 66'(dut_irdy), 66'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      fill_table();
      for (int i = 0; i < 9; i++) begin
        single_beat(tbl[i], $sformatf("vec%0d", i));
      end
      stream(16, 1'b0, "burst");
      stream(16, 1'b1, "stall");
      reset_midflight();
      single_beat(tbl[0], "post_reset");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
